// File: rtl/us_ip_rx_dispatch.sv
// us_ip_rx_dispatch: route IP payload frames to the UDP or ICMP stream (or discard them) and count them
module us_ip_rx_dispatch #(
    parameter logic [7:0] UDP_PROTO    = 8'h11,
    parameter logic [7:0] ICMP_PROTO   = 8'h01,
    parameter bit         ACCEPT_BCAST = 1'b1,
    parameter int         CNT_W        = 16
) (
    input  logic             rx_axis_aclk,
    input  logic             rx_axis_aresetn,
    input  logic [63:0]      ip_rx_axis_tdata,
    input  logic [7:0]       ip_rx_axis_tkeep,
    input  logic             ip_rx_axis_tvalid,
    input  logic             ip_rx_axis_tlast,
    input  logic             ip_rx_axis_tuser,
    input  logic [15:0]      ip_type,
    input  logic [31:0]      recv_dst_ip_addr,
    input  logic [31:0]      local_ip_addr,
    output logic [63:0]      udp_rx_axis_tdata,
    output logic [7:0]       udp_rx_axis_tkeep,
    output logic             udp_rx_axis_tvalid,
    output logic             udp_rx_axis_tlast,
    output logic             udp_rx_axis_tuser,
    output logic [63:0]      icmp_rx_axis_tdata,
    output logic [7:0]       icmp_rx_axis_tkeep,
    output logic             icmp_rx_axis_tvalid,
    output logic             icmp_rx_axis_tlast,
    output logic             icmp_rx_axis_tuser,
    output logic [CNT_W-1:0] udp_frame_cnt,
    output logic [CNT_W-1:0] icmp_frame_cnt,
    output logic [CNT_W-1:0] drop_frame_cnt,
    output logic [CNT_W-1:0] err_frame_cnt
);
    typedef enum logic [1:0] {IDLE, FWD_UDP, FWD_ICMP, DROP} state_t;

    state_t state, state_nxt, cls, route;
    logic   addr_ok, to_udp, to_icmp;
    logic   unused_type_hi;

    // only the protocol byte takes part in classification
    assign unused_type_hi = ^ip_type[15:8];

    // classify on the first beat, otherwise follow the locked route
    always_comb begin
        addr_ok   = (recv_dst_ip_addr == local_ip_addr) ||
                    (ACCEPT_BCAST && recv_dst_ip_addr == 32'hFFFF_FFFF);
        cls       = !addr_ok                   ? DROP :
                    ip_type[7:0] == UDP_PROTO  ? FWD_UDP :
                    ip_type[7:0] == ICMP_PROTO ? FWD_ICMP : DROP;
        route     = (state == IDLE) ? cls : state;
        to_udp    = ip_rx_axis_tvalid && route == FWD_UDP;
        to_icmp   = ip_rx_axis_tvalid && route == FWD_ICMP;
        state_nxt = !ip_rx_axis_tvalid ? state :
                    ip_rx_axis_tlast   ? IDLE : route;
    end

    // route state register
    always_ff @(posedge rx_axis_aclk) begin
        if (!rx_axis_aresetn) state <= IDLE;
        else                  state <= state_nxt;
    end

    // registered output streams; the unselected port is held at zero
    always_ff @(posedge rx_axis_aclk) begin
        if (!rx_axis_aresetn) begin
            udp_rx_axis_tdata   <= '0;
            udp_rx_axis_tkeep   <= '0;
            udp_rx_axis_tvalid  <= 1'b0;
            udp_rx_axis_tlast   <= 1'b0;
            udp_rx_axis_tuser   <= 1'b0;
            icmp_rx_axis_tdata  <= '0;
            icmp_rx_axis_tkeep  <= '0;
            icmp_rx_axis_tvalid <= 1'b0;
            icmp_rx_axis_tlast  <= 1'b0;
            icmp_rx_axis_tuser  <= 1'b0;
        end else begin
            udp_rx_axis_tdata   <= to_udp ? ip_rx_axis_tdata : '0;
            udp_rx_axis_tkeep   <= to_udp ? ip_rx_axis_tkeep : '0;
            udp_rx_axis_tvalid  <= to_udp;
            udp_rx_axis_tlast   <= to_udp && ip_rx_axis_tlast;
            udp_rx_axis_tuser   <= to_udp && ip_rx_axis_tuser;
            icmp_rx_axis_tdata  <= to_icmp ? ip_rx_axis_tdata : '0;
            icmp_rx_axis_tkeep  <= to_icmp ? ip_rx_axis_tkeep : '0;
            icmp_rx_axis_tvalid <= to_icmp;
            icmp_rx_axis_tlast  <= to_icmp && ip_rx_axis_tlast;
            icmp_rx_axis_tuser  <= to_icmp && ip_rx_axis_tuser;
        end
    end

    // per-class frame counters, bumped when a frame's tlast beat is accepted
    always_ff @(posedge rx_axis_aclk) begin
        if (!rx_axis_aresetn) begin
            udp_frame_cnt  <= '0;
            icmp_frame_cnt <= '0;
            drop_frame_cnt <= '0;
            err_frame_cnt  <= '0;
        end else if (ip_rx_axis_tvalid && ip_rx_axis_tlast) begin
            if (to_udp)                          udp_frame_cnt  <= udp_frame_cnt + 1'b1;
            if (to_icmp)                         icmp_frame_cnt <= icmp_frame_cnt + 1'b1;
            if (!to_udp && !to_icmp)             drop_frame_cnt <= drop_frame_cnt + 1'b1;
            if ((to_udp || to_icmp) && ip_rx_axis_tuser) err_frame_cnt <= err_frame_cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_us_ip_rx_dispatch.sv
// tb_us_ip_rx_dispatch: randomized and directed check of the dispatcher against a frame-level model
module tb_us_ip_rx_dispatch;
    localparam logic [31:0] LOCAL = 32'hC0A8_010B;

    logic        clk = 1'b0;
    logic        rstn;
    logic [63:0] tdata;
    logic [7:0]  tkeep;
    logic        tvalid, tlast, tuser;
    logic [15:0] ip_type;
    logic [31:0] dst, local_ip;

    logic [63:0] u_td[2], i_td[2];
    logic [7:0]  u_tk[2], i_tk[2];
    logic        u_tv[2], u_tl[2], u_tu[2], i_tv[2], i_tl[2], i_tu[2];
    logic [15:0] c_u[2], c_i[2], c_d[2], c_e[2];

    int tests = 0;
    int fails = 0;

    // model: route of the frame in progress (0 none, 1 udp, 2 icmp, 3 drop) and counts
    int          route[2];
    logic [15:0] m_u[2], m_i[2], m_d[2], m_e[2];
    logic [63:0] e_ud[2], e_id[2];
    logic [10:0] e_uc[2], e_ic[2];

    always #5 clk = ~clk;

    us_ip_rx_dispatch dut0 (
        .rx_axis_aclk(clk), .rx_axis_aresetn(rstn),
        .ip_rx_axis_tdata(tdata), .ip_rx_axis_tkeep(tkeep), .ip_rx_axis_tvalid(tvalid),
        .ip_rx_axis_tlast(tlast), .ip_rx_axis_tuser(tuser),
        .ip_type(ip_type), .recv_dst_ip_addr(dst), .local_ip_addr(local_ip),
        .udp_rx_axis_tdata(u_td[0]), .udp_rx_axis_tkeep(u_tk[0]), .udp_rx_axis_tvalid(u_tv[0]),
        .udp_rx_axis_tlast(u_tl[0]), .udp_rx_axis_tuser(u_tu[0]),
        .icmp_rx_axis_tdata(i_td[0]), .icmp_rx_axis_tkeep(i_tk[0]), .icmp_rx_axis_tvalid(i_tv[0]),
        .icmp_rx_axis_tlast(i_tl[0]), .icmp_rx_axis_tuser(i_tu[0]),
        .udp_frame_cnt(c_u[0]), .icmp_frame_cnt(c_i[0]), .drop_frame_cnt(c_d[0]), .err_frame_cnt(c_e[0])
    );

    us_ip_rx_dispatch #(.ACCEPT_BCAST(1'b0)) dut1 (
        .rx_axis_aclk(clk), .rx_axis_aresetn(rstn),
        .ip_rx_axis_tdata(tdata), .ip_rx_axis_tkeep(tkeep), .ip_rx_axis_tvalid(tvalid),
        .ip_rx_axis_tlast(tlast), .ip_rx_axis_tuser(tuser),
        .ip_type(ip_type), .recv_dst_ip_addr(dst), .local_ip_addr(local_ip),
        .udp_rx_axis_tdata(u_td[1]), .udp_rx_axis_tkeep(u_tk[1]), .udp_rx_axis_tvalid(u_tv[1]),
        .udp_rx_axis_tlast(u_tl[1]), .udp_rx_axis_tuser(u_tu[1]),
        .icmp_rx_axis_tdata(i_td[1]), .icmp_rx_axis_tkeep(i_tk[1]), .icmp_rx_axis_tvalid(i_tv[1]),
        .icmp_rx_axis_tlast(i_tl[1]), .icmp_rx_axis_tuser(i_tu[1]),
        .udp_frame_cnt(c_u[1]), .icmp_frame_cnt(c_i[1]), .drop_frame_cnt(c_d[1]), .err_frame_cnt(c_e[1])
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // advance one clock, apply the frame rules to the sampled beat, then compare
    task automatic step();
        int  r;
        bit  ok;
        @(posedge clk);
        for (int d = 0; d < 2; d++) begin
            e_ud[d] = '0; e_id[d] = '0; e_uc[d] = '0; e_ic[d] = '0;
            if (!rstn) begin
                route[d] = 0; m_u[d] = 0; m_i[d] = 0; m_d[d] = 0; m_e[d] = 0;
            end else if (tvalid) begin
                r = route[d];
                if (r == 0) begin
                    ok = (dst == local_ip) || (d == 0 && dst == 32'hFFFF_FFFF);
                    r  = !ok ? 3 : ip_type[7:0] == 8'h11 ? 1 : ip_type[7:0] == 8'h01 ? 2 : 3;
                end
                if (r == 1) begin e_ud[d] = tdata; e_uc[d] = {tkeep, 1'b1, tlast, tuser}; end
                if (r == 2) begin e_id[d] = tdata; e_ic[d] = {tkeep, 1'b1, tlast, tuser}; end
                if (tlast) begin
                    if (r == 1) m_u[d]++;
                    if (r == 2) m_i[d]++;
                    if (r == 3) m_d[d]++;
                    if (r != 3 && tuser) m_e[d]++;
                    route[d] = 0;
                end else route[d] = r;
            end
        end
        #1;
        for (int d = 0; d < 2; d++) begin
            check($sformatf("udp_data%0d", d), u_td[d], e_ud[d]);
            check($sformatf("udp_ctl%0d", d), 64'({u_tk[d], u_tv[d], u_tl[d], u_tu[d]}), 64'(e_uc[d]));
            check($sformatf("icmp_data%0d", d), i_td[d], e_id[d]);
            check($sformatf("icmp_ctl%0d", d), 64'({i_tk[d], i_tv[d], i_tl[d], i_tu[d]}), 64'(e_ic[d]));
            check($sformatf("counters%0d", d), {c_u[d], c_i[d], c_d[d], c_e[d]}, {m_u[d], m_i[d], m_d[d], m_e[d]});
        end
    endtask

    task automatic beat(input bit v, input bit l, input bit u);
        tvalid = v; tlast = l; tuser = u;
        tdata  = {$urandom, $urandom};
        tkeep  = l ? 8'($urandom_range(1, 255)) : 8'hFF;
        step();
    endtask

    task automatic frame(input logic [31:0] fd, input logic [15:0] ft, input int n,
                         input int gap_pct, input bit eu, input bit mutate);
        dst = fd; ip_type = ft;
        for (int i = 0; i < n; i++) begin
            while (gap_pct > 0 && $urandom_range(99) < gap_pct) beat(1'b0, 1'($urandom_range(1)), 1'b0);
            if (mutate && i > 0) begin
                ip_type = 16'($urandom);
                dst     = $urandom_range(1) ? LOCAL : 32'hFFFF_FFFF;
            end
            beat(1'b1, i == n - 1, (i == n - 1) ? eu : 1'($urandom_range(1)));
        end
    endtask

    function automatic logic [31:0] pick_dst();
        case ($urandom_range(3))
            0, 1:    return LOCAL;
            2:       return 32'hFFFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    function automatic logic [15:0] pick_type();
        case ($urandom_range(4))
            0:       return 16'h0011;
            1:       return 16'h0001;
            2:       return {8'($urandom), 8'h11};
            3:       return 16'h0006;
            default: return 16'($urandom);
        endcase
    endfunction

    initial begin
        local_ip = LOCAL; dst = LOCAL; ip_type = 16'h0011;
        tdata = '0; tkeep = '0; tvalid = 1'b0; tlast = 1'b0; tuser = 1'b0;
        rstn = 1'b0;
        for (int d = 0; d < 2; d++) route[d] = 0;
        step(); step();
        rstn = 1'b1;
        beat(1'b0, 1'b0, 1'b0);
        frame(LOCAL, 16'h0011, 3, 0, 1'b0, 1'b0);
        frame(LOCAL, 16'h0001, 2, 0, 1'b0, 1'b0);
        frame(LOCAL, 16'h0011, 2, 0, 1'b0, 1'b0);
        frame(32'hC0A8_010C, 16'h0011, 4, 0, 1'b0, 1'b0);
        frame(LOCAL, 16'h0006, 4, 0, 1'b0, 1'b0);
        frame(32'hFFFF_FFFF, 16'h0011, 1, 0, 1'b0, 1'b0);
        frame(LOCAL, 16'h0011, 1, 0, 1'b0, 1'b0);
        dst = LOCAL; ip_type = 16'h0011;
        beat(1'b1, 1'b0, 1'b0);
        beat(1'b0, 1'b0, 1'b0);
        beat(1'b0, 1'b0, 1'b0);
        ip_type = 16'h0001; dst = 32'hC0A8_0199;
        beat(1'b1, 1'b0, 1'b0);
        beat(1'b1, 1'b1, 1'b1);
        dst = LOCAL; ip_type = 16'h0011;
        beat(1'b1, 1'b0, 1'b0);
        rstn = 1'b0;
        beat(1'b1, 1'b0, 1'b0);
        rstn = 1'b1;
        beat(1'b0, 1'b0, 1'b0);
        beat(1'b1, 1'b0, 1'b0);
        beat(1'b1, 1'b1, 1'b0);
        frame(LOCAL, 16'h0001, 3, 0, 1'b1, 1'b0);
        for (int f = 0; f < 200; f++) begin
            frame(pick_dst(), pick_type(), $urandom_range(1, 6), $urandom_range(1) ? 30 : 0,
                  1'($urandom_range(1)), $urandom_range(3) == 0);
            if ($urandom_range(19) == 0) begin
                rstn = 1'b0;
                beat(1'($urandom_range(1)), 1'b0, 1'b0);
                rstn = 1'b1;
            end
        end
        beat(1'b0, 1'b0, 1'b0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
